layernorm_sum_accumulator: RTL and testbench

Streaming reduction stage that feeds the LayerNorm mean calculation unit. It accepts one signed fixed-point element per cycle over a valid/ready handshake and accumulates exactly D_MODEL_VAL elements per vector. It then presents the full-precision vector sum as a single-cycle `sum_valid_out` pulse, wired directly to the mean unit's `sum_in`/`sum_valid_in`.

---
 rtl/layernorm_sum_accumulator_if.sv | 23 ++
 rtl/layernorm_sum_accumulator.sv | 103 ++++++++++
 tb/tb_layernorm_sum_accumulator.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/layernorm_sum_accumulator_if.sv
// rtl/layernorm_sum_accumulator_if.sv - element stream in, vector sum out, for the LayerNorm sum accumulator
interface layernorm_sum_accumulator_if #(
  parameter int DATA_WIDTH = 16,
  parameter int SUM_WIDTH  = 26
);
  logic signed [DATA_WIDTH-1:0] data_in;
  logic                         data_valid_in;
  logic                         data_last_in;
  logic                         data_ready_out;
  logic signed [SUM_WIDTH-1:0]  sum_out;
  logic                         sum_valid_out;
  logic                         len_error_out;

  modport slave (
    input  data_in, data_valid_in, data_last_in,
    output data_ready_out, sum_out, sum_valid_out, len_error_out
  );

  modport master (
    output data_in, data_valid_in, data_last_in,
    input  data_ready_out, sum_out, sum_valid_out, len_error_out
  );
endinterface

// File: rtl/layernorm_sum_accumulator.sv
// rtl/layernorm_sum_accumulator.sv - accumulates D_MODEL_VAL signed elements into one full-precision sum pulse
module layernorm_sum_accumulator #(
  parameter int D_MODEL_VAL = 128,
  parameter int DATA_WIDTH  = 16,
  parameter int DATA_FRAC   = 10,
  parameter int SUM_WIDTH   = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_in,
  output logic busy_out,
  layernorm_sum_accumulator_if.slave s
);
  localparam int CNT_W = $clog2(D_MODEL_VAL);

  generate
    if (SUM_WIDTH < DATA_WIDTH + CNT_W) begin : g_bad_width
      $error("SUM_WIDTH too narrow for D_MODEL_VAL elements of DATA_WIDTH");
    end
    if ((D_MODEL_VAL < 4) || (D_MODEL_VAL > 512) || ((1 << CNT_W) != D_MODEL_VAL)) begin : g_bad_len
      $error("D_MODEL_VAL must be a power of two in 4..512");
    end
    if (DATA_FRAC >= DATA_WIDTH) begin : g_bad_frac
      $error("DATA_FRAC must be smaller than DATA_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                      state_q, state_d;
  logic signed [SUM_WIDTH-1:0] acc_q, acc_d;
  logic signed [SUM_WIDTH-1:0] sum_q, sum_d;
  logic signed [SUM_WIDTH-1:0] acc_next;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        len_err_q, len_err_d;
  logic                        ready_q, ready_d;
  logic                        accept;
  logic                        count_full;

  assign accept     = s.data_valid_in && ready_q;
  assign count_full = (count_q == CNT_W'(D_MODEL_VAL - 1));
  assign acc_next   = acc_q + {{(SUM_WIDTH-DATA_WIDTH){s.data_in[DATA_WIDTH-1]}}, s.data_in};

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    sum_d     = sum_q;
    len_err_d = len_err_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (clear_in) begin
          // Abort wins over a same-cycle accept; the element is dropped.
          state_d = IDLE;
          acc_d   = '0;
          count_d = '0;
        end else if (accept) begin
          if (s.data_last_in || count_full) begin
            sum_d     = acc_next;
            len_err_d = s.data_last_in ^ count_full;
            state_d   = DONE;
          end else begin
            acc_d   = acc_next;
            count_d = count_q + 1'b1;
            state_d = ACCUM;
          end
        end
      end
      DONE: begin
        acc_d   = '0;
        count_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Registered ready: drop it exactly for the cycle the FSM sits in DONE.
    ready_d = (state_d != DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      count_q   <= '0;
      sum_q     <= '0;
      len_err_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      sum_q     <= sum_d;
      len_err_q <= len_err_d;
      ready_q   <= ready_d;
    end
  end

  assign s.data_ready_out = ready_q;
  assign s.sum_out        = sum_q;
  assign s.sum_valid_out  = (state_q == DONE);
  assign s.len_error_out  = (state_q == DONE) && len_err_q;
  assign busy_out         = (state_q != IDLE);
endmodule

// File: tb/tb_layernorm_sum_accumulator.sv
// tb/tb_layernorm_sum_accumulator.sv - scoreboard bench for layernorm_sum_accumulator at D_MODEL_VAL=4
module tb_layernorm_sum_accumulator;
  localparam int D  = 4;
  localparam int DW = 16;
  localparam int SW = 26;

  typedef struct {
    longint sum;
    longint err;
    longint cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   clear_in = 1'b0;
  logic   busy_out;
  int     tests_run = 0;
  int     tests_failed = 0;
  longint cyc = 0;
  longint acc_cyc;
  longint p1, p2;
  exp_t   exp_q[$];

  layernorm_sum_accumulator_if #(.DATA_WIDTH(DW), .SUM_WIDTH(SW)) s ();

  layernorm_sum_accumulator #(
    .D_MODEL_VAL(D), .DATA_WIDTH(DW), .DATA_FRAC(10), .SUM_WIDTH(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear_in(clear_in), .busy_out(busy_out), .s(s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint expv);
    tests_run++;
    if (got !== expv) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  // Drives one element and returns at the posedge that accepts it.
  task automatic send(input longint data, input bit last);
    bit rdy;
    @(negedge clk);
    s.data_in       = DW'(data);
    s.data_valid_in = 1'b1;
    s.data_last_in  = last;
    for (int i = 0; i < 20; i++) begin
      rdy     = s.data_ready_out;
      acc_cyc = cyc;
      @(posedge clk);
      if (rdy) return;
      @(negedge clk);
    end
    check("send_timeout", 0, 1);
  endtask

  task automatic idle();
    @(negedge clk);
    s.data_valid_in = 1'b0;
    s.data_last_in  = 1'b1;
    s.data_in       = 16'h7fff;
  endtask

  task automatic expect_sum(input longint sum, input longint err);
    exp_t e;
    e.sum = sum;
    e.err = err;
    e.cyc = acc_cyc + 1;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (s.sum_valid_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sum_out", longint'(s.sum_out), e.sum);
          check("len_error_out", longint'(s.len_error_out), e.err);
          check("pulse_cycle", cyc, e.cyc);
        end
      end else if (s.len_error_out) begin
        check("len_error_without_valid", 1, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    s.data_in       = '0;
    s.data_valid_in = 1'b0;
    s.data_last_in  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", longint'(s.data_ready_out), 0);
    check("rst_sum", longint'(s.sum_out), 0);
    check("rst_valid", longint'(s.sum_valid_out), 0);
    check("rst_busy", longint'(busy_out), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", longint'(s.data_ready_out), 1);

    // Basic vector; ready low in the pulse cycle only.
    send(1024, 0); send(2048, 0); send(-512, 0); send(512, 1);
    expect_sum(3072, 0);
    @(negedge clk);
    s.data_valid_in = 1'b0;
    check("ready_in_done", longint'(s.data_ready_out), 0);
    check("busy_in_done", longint'(busy_out), 1);
    @(negedge clk);
    check("ready_after_done", longint'(s.data_ready_out), 1);
    check("busy_after_done", longint'(busy_out), 0);

    // Back-to-back extremes with continuous valid.
    for (int i = 0; i < D; i++) send(-32768, i == D-1);
    expect_sum(-131072, 0);
    p1 = acc_cyc + 1;
    for (int i = 0; i < D; i++) send(32767, i == D-1);
    expect_sum(131068, 0);
    p2 = acc_cyc + 1;
    check("pulse_spacing", p2 - p1, D + 1);
    idle();

    // Random valid gaps.
    for (int i = 1; i <= D; i++) begin
      while ($urandom_range(1) == 0) idle();
      send(i, i == D);
    end
    expect_sum(10, 0);
    idle();

    // Early last then a clean vector.
    send(100, 0); send(200, 1);
    expect_sum(300, 1);
    for (int i = 0; i < D; i++) send(3, i == D-1);
    expect_sum(12, 0);
    idle();

    // Missing last closes at D elements.
    for (int i = 0; i < D; i++) send(10, 0);
    expect_sum(40, 1);
    idle();

    // Clear drops the partial vector and the same-cycle element.
    send(7, 0); send(7, 0);
    @(negedge clk);
    clear_in = 1'b1;
    s.data_in = 16'd99;
    s.data_valid_in = 1'b1;
    s.data_last_in = 1'b1;
    @(negedge clk);
    clear_in = 1'b0;
    s.data_valid_in = 1'b0;
    check("ready_after_clear", longint'(s.data_ready_out), 1);
    check("busy_after_clear", longint'(busy_out), 0);
    for (int i = 0; i < D; i++) send(5, i == D-1);
    expect_sum(20, 0);
    idle();
    repeat (2) @(negedge clk);

    // Async reset mid-vector.
    send(1000, 0); send(1000, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_sum", longint'(s.sum_out), 0);
    check("midrst_valid", longint'(s.sum_valid_out), 0);
    check("midrst_busy", longint'(busy_out), 0);
    check("midrst_ready", longint'(s.data_ready_out), 0);
    s.data_valid_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < D; i++) send(-6, i == D-1);
    expect_sum(-24, 0);
    idle();

    repeat (4) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
